// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter
// and the single-port data memory.
interface dmem_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [31:0]       addr0;
  logic [31:0]       addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic              err0;
  logic              err1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic [31:0]       mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1,
    input  addr0, addr1, wdata0, wdata1,
    input  mem_rdata,
    output gnt0, gnt1, done0, done1,
    output err0, err1, rdata0, rdata1,
    output mem_addr, mem_wdata,
    output mem_read, mem_write
  );

  modport master (
    output req0, req1, we0, we1,
    output addr0, addr1, wdata0, wdata1,
    output mem_rdata,
    input  gnt0, gnt1, done0, done1,
    input  err0, err1, rdata0, rdata1,
    input  mem_addr, mem_wdata,
    input  mem_read, mem_write
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and access sequencer for the
// single-port 256x32 data memory (grant, strobe, done: 3 cycles).
module dmem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t            state;
  state_t            nstate;
  logic              last;
  logic              own;
  logic              we_q;
  logic              err_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              any_req;
  logic              win0;
  logic              win1;
  logic              in_rng;

  assign any_req = bus.req0 | bus.req1;
  // on a tie the port that did not win last time goes first
  assign win1    = bus.req1 & (~bus.req0 | ~last);
  assign win0    = any_req & ~win1;
  assign in_rng  = (addr_q[31:ADDR_W] == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (any_req) nstate = ACCESS;
      ACCESS:  nstate = RESP;
      RESP:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    bus.gnt0      = 1'b0;
    bus.gnt1      = 1'b0;
    bus.done0     = 1'b0;
    bus.done1     = 1'b0;
    bus.err0      = 1'b0;
    bus.err1      = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    unique case (state)
      IDLE: begin
        bus.gnt0 = win0;
        bus.gnt1 = win1;
      end
      ACCESS: begin
        bus.mem_read  = in_rng & ~we_q;
        bus.mem_write = in_rng & we_q;
      end
      RESP: begin
        bus.done0 = ~own;
        bus.done1 = own;
        bus.err0  = ~own & err_q;
        bus.err1  = own & err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last     <= 1'b1;
      own      <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        own     <= win1;
        last    <= win1;
        we_q    <= win1 ? bus.we1 : bus.we0;
        addr_q  <= win1 ? bus.addr1 : bus.addr0;
        wdata_q <= win1 ? bus.wdata1 : bus.wdata0;
      end
      if (state == ACCESS) begin
        err_q <= ~in_rng;
        if (in_rng && !we_q) begin
          if (own) rdata1_q <= bus.mem_rdata;
          else     rdata0_q <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the single-port 256×32 data memory. It shares the memory between the pipeline MEM stage (port 0) and the loader/debug port (port 1) using round-robin arbitration, with a req/gnt/done handshake. It drives the memory's `addr`, `write_data`, `memread` and `memwrite` inputs, and registers the memory's combinational `read_data` output back to the granted requester.

## Interface
- `DATA_W`, 32, data word width
- `ADDR_W`, 8, implemented word-address bits (256 words); the upper 32-`ADDR_W` bits must be zero
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req0`, `req1` in 1: access request; held high until the matching `gnt`.
- `we0`, `we1` in 1: 1 = write, 0 = read; qualified by `req`.
- `addr0`, `addr1` in 32: word address.
- `wdata0`, `wdata1` in DATA_W: write data.
- `gnt0`, `gnt1` out 1: request accepted this cycle (combinational, IDLE state only).
- `done0`, `done1` out 1: one-cycle completion pulse.
- `err0`, `err1` out 1: valid with `done`; out-of-range address, no memory access made.
- `rdata0`, `rdata1` out DATA_W: read result; holds its value until the port's next read completes.
- `mem_addr` out 32: to memory `addr`.
- `mem_wdata` out DATA_W: to memory `write_data`.
- `mem_read`, `mem_write` out 1: to memory `memread` / `memwrite`.
- `mem_rdata` in DATA_W: from memory `read_data`.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any `req` is high, select a winner and assert its `gnt`.
  - Latch the winner's `we`, `addr` and `wdata`, plus the owner id, then go to ACCESS.
  - With no request, stay in IDLE.
- Arbitration is round-robin on a `last` register.
  - When only one port requests, that port wins.
  - When both request, the port other than `last` wins.
  - `last` updates to the winner on every grant; it resets to 1, so port 0 wins the first tie.
- ACCESS:
  - In range (`addr[31:ADDR_W]` == 0): drive `mem_addr` = latched address and `mem_wdata` = latched data. Assert exactly one of `mem_read` (`we`=0) or `mem_write` (`we`=1) for this single cycle.
  - For a read, capture `mem_rdata` into the owner's `rdata` at the end of the cycle.
  - Out of range: no strobe; set the error flag; `rdata` is unchanged.
  - Always go to RESP.
- RESP: pulse the owner's `done` (and `err` if flagged), then go to IDLE. No grant is issued in RESP.
- `mem_read` and `mem_write` are never both high. Both are 0 in IDLE and RESP.
- `mem_addr` and `mem_wdata` are held at their latched values outside ACCESS, so the memory sees no spurious address changes.
- A `req` that drops before `gnt` is ignored. The non-winning port keeps `req` high and is served at the next IDLE.

## Timing
- Reset values:
  - state IDLE, `last` = 1.
  - All `gnt`, `done`, `err` = 0; `rdata0`/`rdata1` = 0.
  - `mem_read` = `mem_write` = 0; `mem_addr` = 0, `mem_wdata` = 0.
- Latency: `gnt` in cycle T, memory strobe in T+1, `done` (and `rdata` valid) in T+2.
- Earliest next grant is T+3, giving a throughput of one access per 3 cycles.
- `rdata` is registered, so it is valid in the same cycle as `done`.
- Reset asserted mid-operation (ACCESS or RESP):
  - The transaction is aborted at once; strobes drop asynchronously.
  - No `done` is issued, and the requester must re-request.
  - A write already strobed in ACCESS may or may not have landed in memory.
- Both ports requesting continuously produce a strict alternation of grants: 0, 1, 0, 1, …

## Test plan
- Reset then single read: port 0 reads addr 5 with DMEM[5]=0x0000_00A5.
  - Required: `gnt0` at T, `mem_read`=1 and `mem_addr`=5 only at T+1, `done0` at T+2, `rdata0`=0x0000_00A5.
- Write then read-back:
  - Port 1 writes 0xDEAD_BEEF to addr 0x10: `mem_write` high for exactly one cycle.
  - Port 1 then reads addr 0x10: `rdata1`=0xDEAD_BEEF.
- Tie after reset: `req0`=`req1`=1 held for 4 transactions.
  - Required: grants 0, 1, 0, 1; each `done` goes only to its owner; `rdata1` unchanged by port 0's reads.
- Out of range: port 0 reads addr 0x100.
  - Required: no `mem_read`/`mem_write` pulse, `done0`=`err0`=1 at T+2, `rdata0` unchanged.
- Reset mid-ACCESS: `rst_n` low during a write strobe.
  - Required: `mem_write` drops immediately, no `done`, state IDLE, all outputs at their reset values.
- Back-to-back from one port: `req0` held with 3 reads.
  - Required: grants spaced exactly 3 cycles apart, and the strobe never overlaps a grant cycle.
